// File: rtl/esticador_pkg.sv
// Shared types and helpers for the pulse stretcher: per-channel state encoding
// and the counter-width calculation used by every channel.
package esticador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ATIVO = 2'd1,
    PAUSA = 2'd2
  } estado_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough to hold the largest preload (LARGURA-1 or PAUSA-1), never below 1 bit.
  function automatic int largura_cnt(input int largura, input int pausa);
    int m;
    m = max_int(largura, pausa);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/esticador_canal.sv
// Single-channel pulse stretcher: IDLE -> ATIVO (level high) -> PAUSA (holdoff) -> IDLE,
// with a sticky flag for dropped events. Build with ESTICADOR_REDISPARO_EN to retrigger in ATIVO.
module esticador_canal
  import esticador_pkg::*;
#(
  parameter int LARGURA = 4,
  parameter int PAUSA   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada_i,
  input  logic limpa_perdido_i,
  output logic saida_o,
  output logic ocupado_o,
  output logic perdido_o
);

  localparam int CW = largura_cnt(LARGURA, PAUSA);
  localparam logic [CW-1:0] CNT_LARG  = CW'(LARGURA - 1);
  localparam logic [CW-1:0] CNT_PAUSA = (PAUSA > 0) ? CW'(PAUSA - 1) : '0;
  localparam bit SEM_PAUSA = (PAUSA == 0);

`ifdef ESTICADOR_REDISPARO_EN
  localparam bit REDISPARO = 1'b1;
`else
  localparam bit REDISPARO = 1'b0;
`endif

  estado_t       estado_q;
  logic [CW-1:0] cnt_q;
  logic          saida_q;
  logic          perdido_q;
  logic          entrada_ant_q;
  logic          novo;

  // A held input is one event, so drops and retriggers react only to a rising level.
  assign novo = entrada_i & ~entrada_ant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q      <= esticador_pkg::IDLE;
      cnt_q         <= '0;
      saida_q       <= 1'b0;
      perdido_q     <= 1'b0;
      entrada_ant_q <= 1'b0;
    end else begin
      entrada_ant_q <= entrada_i;
      if (limpa_perdido_i) begin
        perdido_q <= 1'b0;
      end
      case (estado_q)
        esticador_pkg::IDLE: begin
          if (entrada_i) begin
            estado_q <= esticador_pkg::ATIVO;
            cnt_q    <= CNT_LARG;
            saida_q  <= 1'b1;
          end
        end
        esticador_pkg::ATIVO: begin
          if (REDISPARO && novo) begin
            cnt_q <= CNT_LARG;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            if (novo) begin
              perdido_q <= 1'b1;
            end
          end else if (SEM_PAUSA && entrada_i) begin
            // No holdoff: a pulse on the final cycle chains straight into a new level.
            cnt_q <= CNT_LARG;
          end else begin
            saida_q <= 1'b0;
            cnt_q   <= CNT_PAUSA;
            if (SEM_PAUSA) begin
              estado_q <= esticador_pkg::IDLE;
            end else begin
              estado_q <= esticador_pkg::PAUSA;
            end
            if (novo) begin
              perdido_q <= 1'b1;
            end
          end
        end
        esticador_pkg::PAUSA: begin
          if (novo) begin
            perdido_q <= 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            estado_q <= esticador_pkg::IDLE;
          end
        end
        default: begin
          estado_q <= esticador_pkg::IDLE;
          cnt_q    <= '0;
          saida_q  <= 1'b0;
        end
      endcase
    end
  end

  assign saida_o   = saida_q;
  assign ocupado_o = (estado_q != esticador_pkg::IDLE);
  assign perdido_o = perdido_q;

endmodule

// File: rtl/esticador_pulso.sv
// Multi-channel pulse-to-level stretcher; WIDTH independent copies of esticador_canal.
// Optional macro ESTICADOR_REDISPARO_EN: pulses during the high level retrigger it.
module esticador_pulso #(
  parameter int WIDTH   = 2,
  parameter int LARGURA = 4,
  parameter int PAUSA   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada,
  input  logic [WIDTH-1:0] limpa_perdido,
  output logic [WIDTH-1:0] saida,
  output logic [WIDTH-1:0] ocupado,
  output logic [WIDTH-1:0] perdido
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_canal
    esticador_canal #(
      .LARGURA(LARGURA),
      .PAUSA  (PAUSA)
    ) u_canal (
      .clk            (clk),
      .rst            (rst),
      .entrada_i      (entrada[i]),
      .limpa_perdido_i(limpa_perdido[i]),
      .saida_o        (saida[i]),
      .ocupado_o      (ocupado[i]),
      .perdido_o      (perdido[i])
    );
  end

endmodule
